// File: rtl/mips_control_defs.sv
// Shared encodings for the multicycle MIPS control path: FSM state codes,
// primary opcodes, ALU control classes and datapath mux selects.
package mips_control_defs;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12,
        S_ERROR     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [2:0] ALU_RTYPE = 3'b111;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_SUB   = 3'b011;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         return S_R_EXEC;
            OP_LW, OP_SW:                     return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   return S_BRANCH;
            OP_J:                             return S_JUMP;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return S_I_EXEC;
            default:                          return S_ERROR;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_OR;
            OP_ANDI: return ALU_AND;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state; flags the stall that would
// make the count reach LIMIT.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic limit_reached
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (stall) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Current stall is the LIMIT-th one: the caller may still let a
    // simultaneous ready win, so this is only asserted while stalling.
    assign limit_reached = stall && (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with memory-wait timeout and sticky
// illegal-opcode / timeout flags.
module multicycle_control
    import mips_control_defs::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       zero_ext_o,
    output logic [3:0] state_o,
    output logic       illegal_op_o,
    output logic       timeout_o
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q;
    logic       illegal_q, timeout_q;
    logic       set_illegal, set_timeout;
    logic       stall, timer_clear, limit_reached;

    assign stall       = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !mem_ready_i;
    // Any state change restarts the count, which covers entry into every wait state.
    assign timer_clear = (state_d != state_q);

    mem_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk           (clk),
        .reset         (reset),
        .clear         (timer_clear),
        .stall         (stall),
        .limit_reached (limit_reached)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opcode_q <= opcode_i;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        set_illegal  = 1'b0;
        set_timeout  = 1'b0;
        pc_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_REG;
        alu_op_o     = '0;
        pc_src_o     = PC_SRC_ALU;
        zero_ext_o   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                alu_op_o    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (limit_reached) begin
                    state_d     = S_ERROR;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b_o = SRC_B_IMM_SH;
                alu_op_o    = ALU_ADD;
                state_d     = decode_target(opcode_i);
                set_illegal = (state_d == S_ERROR);
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_ADD;
                state_d     = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else if (limit_reached) begin
                    state_d     = S_ERROR;
                    set_timeout = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end else if (limit_reached) begin
                    state_d     = S_ERROR;
                    set_timeout = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_RTYPE;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                alu_op_o    = ALU_RTYPE;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_SRC_ALUOUT;
                pc_write_o  = (opcode_q == OP_BNE) ? !zero_i : zero_i;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o   = PC_SRC_JUMP;
                pc_write_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXEC, S_I_WB: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = imm_alu_op(opcode_q);
                zero_ext_o  = (opcode_q == OP_ORI) || (opcode_q == OP_ANDI);
                if (state_q == S_I_WB) begin
                    reg_write_o = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_I_WB;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    assign state_o      = state_q;
    assign illegal_op_o = illegal_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected state traces and strobe
// tables built from the instruction-level behaviour, plus directed corners.
module tb_multicycle_control;

    localparam int unsigned WL = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode_i = '0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
    logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, zero_ext_o;
    logic [1:0] alu_src_b_o, pc_src_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;
    logic       illegal_op_o, timeout_o;
    logic [16:0] act_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                   6'b000010, 6'b001000, 6'b001101, 6'b001100, 6'b001111};

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .i_or_d_o     (i_or_d_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_src_o     (pc_src_o),
        .zero_ext_o   (zero_ext_o),
        .state_o      (state_o),
        .illegal_op_o (illegal_op_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    assign act_vec = {pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o,
                      reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
                      zero_ext_o};

    // Strobe table per state, for the instruction whose opcode is opc.
    function automatic logic [16:0] expect_vec(input int st, input logic [5:0] opc,
                                               input logic z, input logic r);
        logic pcw, iod, mr, mw, irw, rw, rd, m2r, asa, zx;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        {pcw, iod, mr, mw, irw, rw, rd, m2r, asa, zx} = '0;
        asb = 2'b00; psrc = 2'b00; aop = 3'b000;
        case (st)
            1:  begin mr = 1; asb = 2'b01; aop = 3'b100; irw = r; pcw = r; end
            2:  begin asb = 2'b11; aop = 3'b100; end
            3:  begin asa = 1; asb = 2'b10; aop = 3'b100; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iod = 1; end
            7:  begin asa = 1; aop = 3'b111; end
            8:  begin rw = 1; rd = 1; aop = 3'b111; end
            9:  begin asa = 1; aop = 3'b011; psrc = 2'b01; pcw = (opc == 6'b000100) ? z : !z; end
            10: begin psrc = 2'b10; pcw = 1; end
            11, 12: begin
                asa = 1; asb = 2'b10;
                case (opc)
                    6'b001101: begin aop = 3'b101; zx = 1; end
                    6'b001100: begin aop = 3'b001; zx = 1; end
                    6'b001111: aop = 3'b110;
                    default:   aop = 3'b100;
                endcase
                rw = (st == 12);
            end
            default: ;
        endcase
        return {pcw, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, psrc, zx};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready_i = 1'b0; zero_i = 1'b0; opcode_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || act_vec !== '0 || illegal_op_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d outs=%h ill=%b to=%b required 0", state_o, act_vec, illegal_op_o, timeout_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0; mem_ready_i = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || act_vec !== '0) begin
            errors++;
            $display("FAIL release_idle: state=%0d outs=%h required state 0 outs 0", state_o, act_vec);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd1 || pc_write_o !== 1'b1 || ir_write_o !== 1'b1) begin
            errors++;
            $display("FAIL release_fetch: state=%0d pcw=%b irw=%b required 1 1 1", state_o, pc_write_o, ir_write_o);
        end
        @(negedge clk);
        opcode_i = 6'b000010;
        #1;
        checks++;
        if (state_o !== 4'd2) begin
            errors++;
            $display("FAIL release_decode: state=%0d required 2", state_o);
        end
        @(negedge clk);
        opcode_i = '0;
        #1;
        checks++;
        if (state_o !== 4'd10 || act_vec !== expect_vec(10, 6'b000010, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL jump: state=%0d outs=%h required 10 %h", state_o, act_vec, expect_vec(10, 6'b000010, 1'b0, 1'b1));
        end
    endtask

    // Expects the DUT to enter FETCH at the next clock edge.
    task automatic test_instructions(input int n);
        for (int i = 0; i < n; i++) begin
            logic [5:0] opc;
            int sf, sm;
            step_t tr[$];
            opc = (i < 10) ? legal_ops[i] : legal_ops[$urandom_range(0, 9)];
            sf  = ($urandom_range(0, 7) == 0) ? int'(WL) - 1 : int'($urandom_range(0, 3));
            sm  = ($urandom_range(0, 7) == 0) ? int'(WL) - 1 : int'($urandom_range(0, 3));
            tr.delete();
            for (int k = 0; k < sf; k++) tr.push_back('{st: 1, rdy: 1'b0});
            tr.push_back('{st: 1, rdy: 1'b1});
            tr.push_back('{st: 2, rdy: 1'($urandom_range(0, 1))});
            case (opc)
                6'b000000: begin tr.push_back('{7, 1'($urandom)}); tr.push_back('{8, 1'($urandom)}); end
                6'b100011: begin
                    tr.push_back('{3, 1'($urandom)});
                    for (int k = 0; k < sm; k++) tr.push_back('{st: 4, rdy: 1'b0});
                    tr.push_back('{4, 1'b1});
                    tr.push_back('{5, 1'($urandom)});
                end
                6'b101011: begin
                    tr.push_back('{3, 1'($urandom)});
                    for (int k = 0; k < sm; k++) tr.push_back('{st: 6, rdy: 1'b0});
                    tr.push_back('{6, 1'b1});
                end
                6'b000100, 6'b000101: tr.push_back('{9, 1'($urandom)});
                6'b000010: tr.push_back('{10, 1'($urandom)});
                default: begin tr.push_back('{11, 1'($urandom)}); tr.push_back('{12, 1'($urandom)}); end
            endcase
            foreach (tr[k]) begin
                logic z;
                logic [16:0] exp;
                z = 1'($urandom_range(0, 1));
                @(negedge clk);
                mem_ready_i = tr[k].rdy;
                zero_i      = z;
                opcode_i    = (tr[k].st == 2) ? opc : 6'($urandom);
                #1;
                exp = expect_vec(tr[k].st, opc, z, tr[k].rdy);
                checks++;
                if (state_o !== 4'(tr[k].st)) begin
                    errors++;
                    $display("FAIL instr_state op=%b step=%0d: actual %0d required %0d", opc, k, state_o, tr[k].st);
                end
                checks++;
                if (act_vec !== exp) begin
                    errors++;
                    $display("FAIL instr_outputs op=%b state=%0d step=%0d: actual %h required %h", opc, tr[k].st, k, act_vec, exp);
                end
            end
            checks++;
            if (illegal_op_o !== 1'b0 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL instr_flags op=%b: ill=%b to=%b required 0 0", opc, illegal_op_o, timeout_o);
            end
        end
    endtask

    task automatic test_ready_wins();
        apply_reset();
        for (int k = 0; k < int'(WL) - 1; k++) begin
            @(negedge clk);
            mem_ready_i = 1'b0;
        end
        @(negedge clk);
        mem_ready_i = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd1 || pc_write_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_wins_fetch: state=%0d pcw=%b required 1 1", state_o, pc_write_o);
        end
        @(negedge clk);
        mem_ready_i = 1'b0; opcode_i = 6'b000010;
        #1;
        checks++;
        if (state_o !== 4'd2 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_wins_decode: state=%0d to=%b required 2 0", state_o, timeout_o);
        end
    endtask

    task automatic test_fetch_timeout();
        apply_reset();
        for (int k = 0; k < int'(WL); k++) begin
            @(negedge clk);
            mem_ready_i = 1'b0;
            #1;
            checks++;
            if (state_o !== 4'd1 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL fetch_stall stall=%0d: state=%0d to=%b required 1 0", k, state_o, timeout_o);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready_i = 1'($urandom_range(0, 1)); zero_i = 1'($urandom);
            #1;
            checks++;
            if (state_o !== 4'd15 || timeout_o !== 1'b1 || illegal_op_o !== 1'b0 || act_vec !== '0) begin
                errors++;
                $display("FAIL fetch_timeout cyc=%0d: state=%0d to=%b ill=%b outs=%h required 15 1 0 0", k, state_o, timeout_o, illegal_op_o, act_vec);
            end
        end
    endtask

    task automatic test_mem_timeout();
        apply_reset();
        @(negedge clk); mem_ready_i = 1'b1;
        @(negedge clk); opcode_i = 6'b100011;
        @(negedge clk); opcode_i = '0;
        for (int k = 0; k < int'(WL); k++) begin
            @(negedge clk);
            mem_ready_i = 1'b0;
            #1;
            checks++;
            if (state_o !== 4'd4) begin
                errors++;
                $display("FAIL mem_read_stall stall=%0d: state=%0d required 4", k, state_o);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd15 || timeout_o !== 1'b1 || act_vec !== '0) begin
            errors++;
            $display("FAIL mem_timeout: state=%0d to=%b outs=%h required 15 1 0", state_o, timeout_o, act_vec);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        @(negedge clk); mem_ready_i = 1'b1;
        @(negedge clk); opcode_i = 6'b111111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            opcode_i = 6'($urandom); mem_ready_i = 1'($urandom);
            #1;
            checks++;
            if (state_o !== 4'd15 || illegal_op_o !== 1'b1 || timeout_o !== 1'b0 || act_vec !== '0) begin
                errors++;
                $display("FAIL illegal_op cyc=%0d: state=%0d ill=%b to=%b outs=%h required 15 1 0 0", k, state_o, illegal_op_o, timeout_o, act_vec);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || illegal_op_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset: state=%0d ill=%b required 0 0", state_o, illegal_op_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        @(negedge clk); mem_ready_i = 1'b1;
        @(negedge clk); opcode_i = 6'b101011;
        @(negedge clk); opcode_i = '0;
        @(negedge clk);
        mem_ready_i = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd6 || mem_write_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_write_setup: state=%0d mw=%b required 6 1", state_o, mem_write_o);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || act_vec !== '0) begin
            errors++;
            $display("FAIL mid_write_reset: state=%0d outs=%h required 0 0", state_o, act_vec);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_instructions(60);
        test_ready_wins();
        test_fetch_timeout();
        test_mem_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum stalled cycles allowed in any memory state before timeout.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode_i  in  6  instruction[31:26] from instruction register.
REQ-005 zero_i  in  1  ALU zero flag.
REQ-006 mem_ready_i  in  1  memory completes current access this cycle.
REQ-007 pc_write_o  out  1  PC load enable.
REQ-008 i_or_d_o  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-009 mem_read_o, mem_write_o, ir_write_o  out  1 each  memory read, memory write and IR load strobes.
REQ-010 reg_write_o, reg_dst_o, mem_to_reg_o  out  1 each  register-file write enable, rd(1)/rt(0) select, MDR(1)/ALUOut(0) select.
REQ-011 alu_src_a_o  out  1  0 PC, 1 register A; alu_src_b_o  out  2  00 B, 01 constant 4, 10 sign/zero-extended imm, 11 imm<<2.
REQ-012 alu_op_o  out  3  ALU control class: 111 R-type, 100 add, 101 or, 001 and, 110 lui, 011 subtract-compare.
REQ-013 pc_src_o  out  2  00 ALU result, 01 ALUOut, 10 jump target; zero_ext_o  out  1  zero-extend immediate.
REQ-014 state_o  out  4  current state code; illegal_op_o, timeout_o  out  1 each  sticky error flags.

Function
REQ-015 States: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12, ERROR 15; every output not listed for a state SHALL be 0.
REQ-016 IDLE: all outputs 0; unconditionally to FETCH next cycle.
REQ-017 FETCH: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=100; ir_write=pc_write=mem_ready_i (same cycle); stay until mem_ready_i, then DECODE.
REQ-018 DECODE: alu_src_b=11, alu_op=100; latch opcode_i internally; 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100/000101->BRANCH, 000010->JUMP, 001000/001101/001100/001111->I_EXEC, any other->ERROR with illegal_op_o set.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100; lw->MEM_READ, sw->MEM_WRITE.
REQ-020 MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready_i, then MEM_WB; MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
REQ-021 MEM_WRITE: mem_write=1, i_or_d=1; wait for mem_ready_i, then FETCH.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111 -> R_WB; R_WB: reg_write=1, reg_dst=1, alu_op=111 -> FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=011, pc_src=01; pc_write=zero_i for beq, ~zero_i for bne; -> FETCH.
REQ-024 JUMP: pc_src=10, pc_write=1 -> FETCH.
REQ-025 I_EXEC and I_WB: alu_src_a=1, alu_src_b=10, alu_op addi 100, ori 101, andi 001, lui 110; zero_ext=1 for ori/andi; I_WB adds reg_write=1, reg_dst=0; I_EXEC->I_WB->FETCH.
REQ-026 Wait counter: cleared on entry to FETCH, MEM_READ, MEM_WRITE; increments each cycle there without mem_ready_i; at WAIT_LIMIT stalled cycles go to ERROR and set timeout_o.
REQ-027 mem_ready_i in the same cycle the counter reaches WAIT_LIMIT: ready wins, normal transition, no timeout.
REQ-028 ERROR: all strobes 0, flags held, remain until reset.
REQ-029 state_o SHALL equal the registered state; only strobes in REQ-017/023 are combinational from inputs.

Reset
REQ-030 reset SHALL force state IDLE, wait counter 0, latched opcode 000000, illegal_op_o=timeout_o=0, all outputs 0, asynchronously and at any point including mid-access.

Structure
REQ-031 State codes, opcode constants and alu_op codes SHALL live in shared include file mips_control_defs, also used by the ALU-control and datapath blocks.
REQ-032 Wait counter SHALL be sub-module mem_wait_timer (clear, stall, limit-reached).

Verification
REQ-033 Reset release, mem_ready_i=1: IDLE, FETCH (pc_write=ir_write=1), DECODE, sequence state_o 0,1,2.
REQ-034 add (opcode 000000), ready=1 -> states 1,2,7,8,1; reg_write=1, reg_dst=1 only in R_WB; alu_op=111 in R_EXEC.
REQ-035 lw with mem_ready_i low 3 cycles in MEM_READ -> 4 cycles in state 4, then MEM_WB with mem_to_reg=1; sw -> mem_write=1 in state 6.
REQ-036 beq zero_i=1 -> pc_write=1, pc_src=01; bne zero_i=1 -> pc_write=0; ori -> alu_op=101, zero_ext=1.
REQ-037 opcode 111111 -> ERROR, illegal_op_o=1 persists; FETCH with mem_ready_i low 15 cycles -> timeout_o=1; ready on 15th stalled cycle -> DECODE, no timeout.
REQ-038 reset asserted mid MEM_WRITE -> outputs 0 immediately, state_o=0.
